// File: rtl/multdiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_unit_if
// Description : Command/result bundle for the iterative multiply/divide unit.
//               The master (issuing stage) drives the start pulses and
//               operands. The slave (multdiv_unit) returns the result,
//               the exception flag, the one-cycle ready strobe and busy.
// Ports       : ctrl_MULT, ctrl_DIV        start pulses (master -> slave)
//               data_operandA/B            operands     (master -> slave)
//               data_result                product low word / quotient
//               data_exception             overflow or divide-by-zero
//               data_resultRDY             one-cycle result-valid strobe
//               busy                       operation in flight
// Revision    : 1.0  initial release
// ============================================================================
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface
`default_nettype wire

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_unit
// Description : Iterative signed 32-bit multiplier / divider. Each operation
//               takes a fixed 33 cycles: 32 add/subtract-shift iterations
//               followed by one finalize cycle that registers the result and
//               pulses data_resultRDY. Multiply uses radix-2 Booth. Divide
//               uses restoring division on magnitudes with a final sign fix.
// Ports       : clock        rising-edge clock
//               ctrl_reset   asynchronous reset, active-low
//               bus          multdiv_unit_if.slave (commands in, results out)
// Revision    : 1.0  initial release
// ============================================================================
module multdiv_unit (
  input  wire logic     clock,
  input  wire logic     ctrl_reset,
  multdiv_unit_if.slave bus
);

  localparam logic [5:0] c_ITERS = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [5:0]  r_cnt;
  logic [31:0] r_op;      // multiplicand (MUL) or divisor magnitude (DIV)
  logic [32:0] r_hi;      // Booth accumulator (MUL) or partial remainder (DIV)
  logic [31:0] r_lo;      // multiplier/product low (MUL) or quotient (DIV)
  logic        r_qm1;     // Booth look-behind bit
  logic        r_neg;     // quotient must be negated
  logic        r_dvz;     // divisor was zero
  logic        r_ovf;     // most-negative / -1
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_rdy;
  logic        r_busy;

  logic        w_running;
  logic        w_fin;
  logic        w_iter;
  logic        w_accept;
  logic        w_go_mul;
  logic        w_go_div;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_booth_sum;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [32:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic [31:0] w_fin_result;
  logic        w_fin_exc;

  assign w_running = (r_state == S_MUL) || (r_state == S_DIV);
  assign w_fin     = w_running && (r_cnt == c_ITERS);
  assign w_iter    = w_running && (r_cnt != c_ITERS);
  // The finalize edge also accepts a start so operations chain with no bubble.
  assign w_accept  = (r_state == S_IDLE) || (r_state == S_DONE) || w_fin;
  assign w_go_mul  = w_accept && bus.ctrl_MULT;
  assign w_go_div  = w_accept && bus.ctrl_DIV && !bus.ctrl_MULT;

  assign w_abs_a = bus.data_operandA[31] ? (~bus.data_operandA + 32'd1) : bus.data_operandA;
  assign w_abs_b = bus.data_operandB[31] ? (~bus.data_operandB + 32'd1) : bus.data_operandB;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_go_mul)      w_state_nxt = S_MUL;
        else if (w_go_div) w_state_nxt = S_DIV;
        else               w_state_nxt = S_IDLE;
      end
      S_MUL, S_DIV: begin
        if (r_cnt == c_ITERS) begin
          if (w_go_mul)      w_state_nxt = S_MUL;
          else if (w_go_div) w_state_nxt = S_DIV;
          else               w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // One iteration of either algorithm
  // --------------------------------------------------------------------------
  // A 33-bit accumulator keeps the Booth partial sum exact even for a
  // most-negative multiplicand.
  always_comb begin
    w_booth_sum = r_hi;
    case ({r_lo[0], r_qm1})
      2'b01:   w_booth_sum = r_hi + {r_op[31], r_op};
      2'b10:   w_booth_sum = r_hi - {r_op[31], r_op};
      default: w_booth_sum = r_hi;
    endcase
  end

  // Remainder stays below the divisor (<= 2^31), so the shifted value fits in
  // 33 bits and bit 32 of the difference is a clean borrow flag.
  assign w_shift = {r_hi[31:0], r_lo[31]};
  assign w_diff  = w_shift - {1'b0, r_op};

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_state == S_MUL) begin
      w_hi_nxt = {w_booth_sum[32], w_booth_sum[32:1]};
      w_lo_nxt = {w_booth_sum[0], r_lo[31:1]};
    end else if (!w_diff[32]) begin
      w_hi_nxt = w_diff;
      w_lo_nxt = {r_lo[30:0], 1'b1};
    end else begin
      w_hi_nxt = w_shift;
      w_lo_nxt = {r_lo[30:0], 1'b0};
    end
  end

  // --------------------------------------------------------------------------
  // Finalize: sign fix and exception flags
  // --------------------------------------------------------------------------
  always_comb begin
    w_fin_result = r_lo;
    w_fin_exc    = 1'b0;
    if (r_state == S_MUL) begin
      w_fin_exc = (r_hi[31:0] != {32{r_lo[31]}});
    end else if (r_dvz) begin
      w_fin_result = 32'd0;
      w_fin_exc    = 1'b1;
    end else if (r_ovf) begin
      w_fin_result = 32'h8000_0000;
      w_fin_exc    = 1'b1;
    end else if (r_neg) begin
      w_fin_result = ~r_lo + 32'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_cnt <= 6'd0;
      r_op  <= 32'd0;
      r_hi  <= 33'd0;
      r_lo  <= 32'd0;
      r_qm1 <= 1'b0;
      r_neg <= 1'b0;
      r_dvz <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_go_mul) begin
      r_cnt <= 6'd0;
      r_op  <= bus.data_operandA;
      r_hi  <= 33'd0;
      r_lo  <= bus.data_operandB;
      r_qm1 <= 1'b0;
    end else if (w_go_div) begin
      r_cnt <= 6'd0;
      r_op  <= w_abs_b;
      r_hi  <= 33'd0;
      r_lo  <= w_abs_a;
      r_neg <= bus.data_operandA[31] ^ bus.data_operandB[31];
      r_dvz <= (bus.data_operandB == 32'd0);
      r_ovf <= (bus.data_operandA == 32'h8000_0000) && (bus.data_operandB == 32'hFFFF_FFFF);
    end else if (w_iter) begin
      r_cnt <= r_cnt + 6'd1;
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_qm1 <= r_lo[0];
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy  <= w_fin;
      r_busy <= (w_state_nxt == S_MUL) || (w_state_nxt == S_DIV);
      if (w_fin) begin
        r_result <= w_fin_result;
        r_exc    <= w_fin_exc;
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_unit
// Description : Self-checking bench for multdiv_unit. Results are predicted
//               with plain 64-bit signed arithmetic; timing is checked by
//               counting clock edges from the start edge (E0).
// Revision    : 1.0  initial release
// ============================================================================
module tb_multdiv_unit;

  logic clock      = 1'b0;
  logic ctrl_reset = 1'b1;
  int   n_cmp      = 0;
  int   n_bad      = 0;

  multdiv_unit_if #(.WIDTH(32)) bus ();

  multdiv_unit dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  // Behavioural reference: plain signed arithmetic on 64-bit integers.
  function automatic void ref_model(input logic is_div, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic e);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      p = sa * sb;
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = sa / sb;
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  // Present a start at the next falling edge so it is sampled at E0; return
  // at E0+1 with the pulse removed and the operands scrambled.
  task automatic start_op(input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Edges after E0 until data_resultRDY is seen (0 if not within 40);
  // busy_ok clears if busy drops before the strobe.
  task automatic wait_rdy(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = bus.busy;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) lat = n;
      else if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2 ctrl_reset = 1'b0;
    #1;
    n_cmp++; if (bus.data_result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.data_result); end
    n_cmp++; if (bus.data_exception !== 1'b0) begin n_bad++; $display("FAIL reset_exc: got %b want 0", bus.data_exception); end
    n_cmp++; if (bus.data_resultRDY !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", bus.data_resultRDY); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    ctrl_reset = 1'b1;
  endtask

  task automatic test_mul_basic;
    int   lat;
    logic bok;
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    wait_rdy(lat, bok);
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL mul_basic_latency: got %0d want 33", lat); end
    n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL mul_basic_busy_held: got %b want 1", bok); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mul_basic_busy_fall: got %b want 0", bus.busy); end
    n_cmp++; if (bus.data_result !== 32'hFFFF_FFD6) begin n_bad++; $display("FAIL mul_basic_result: got %h want ffffffd6", bus.data_result); end
    n_cmp++; if (bus.data_exception !== 1'b0) begin n_bad++; $display("FAIL mul_basic_exc: got %b want 0", bus.data_exception); end
    @(posedge clock);
    #1;
    n_cmp++; if (bus.data_resultRDY !== 1'b0) begin n_bad++; $display("FAIL mul_basic_rdy_fall: got %b want 0", bus.data_resultRDY); end
    n_cmp++; if (bus.data_result !== 32'hFFFF_FFD6) begin n_bad++; $display("FAIL mul_basic_hold: got %h want ffffffd6", bus.data_result); end
  endtask

  task automatic test_directed;
    logic [31:0] ta [12] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                             32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFF9, 32'd100,
                             32'd5,         32'h8000_0000, 32'h8000_0000, 32'hFFFF_FF9C};
    logic [31:0] tb [12] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001,
                             32'h7FFF_FFFF, 32'h0001_2345, 32'd2,         32'd7,
                             32'd0,         32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFF9};
    logic        td [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic [31:0] er;
    logic        ee;
    int          lat;
    logic        bok;
    for (int i = 0; i < 12; i++) begin
      ref_model(td[i], ta[i], tb[i], er, ee);
      start_op(!td[i], td[i], ta[i], tb[i]);
      wait_rdy(lat, bok);
      n_cmp++; if (lat != 33 || bok !== 1'b1) begin n_bad++; $display("FAIL directed_%0d_timing: got lat %0d busy_ok %b want 33/1", i, lat, bok); end
      n_cmp++; if (bus.data_result !== er) begin n_bad++; $display("FAIL directed_%0d_result: %h op %b %h got %h want %h", i, ta[i], td[i], tb[i], bus.data_result, er); end
      n_cmp++; if (bus.data_exception !== ee) begin n_bad++; $display("FAIL directed_%0d_exc: got %b want %b", i, bus.data_exception, ee); end
    end
  endtask

  task automatic test_random;
    logic        d;
    logic [31:0] a, b, er;
    logic        ee;
    int          lat;
    logic        bok;
    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = $urandom_range(0, 255); b = $urandom_range(0, 15) - 8; end
        2: b = b >> $urandom_range(1, 31);
        default: ;
      endcase
      ref_model(d, a, b, er, ee);
      start_op(!d, d, a, b);
      wait_rdy(lat, bok);
      n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL random_%0d_latency: got %0d want 33", i, lat); end
      n_cmp++; if (bus.data_result !== er) begin n_bad++; $display("FAIL random_%0d_result: %h op %b %h got %h want %h", i, a, d, b, bus.data_result, er); end
      n_cmp++; if (bus.data_exception !== ee) begin n_bad++; $display("FAIL random_%0d_exc: got %b want %b", i, bus.data_exception, ee); end
    end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] er, got;
    logic        ee;
    int          pulses, first;
    ref_model(1'b0, 32'h0000_1234, 32'hFFFF_0101, er, ee);
    start_op(1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_0101);
    repeat (9) @(posedge clock);
    @(negedge clock);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd1000;
    bus.data_operandB = 32'd3;
    @(posedge clock);                // E10
    #1;
    bus.ctrl_DIV = 1'b0;
    pulses = 0;
    first  = 0;
    got    = 32'd0;
    for (int n = 11; n <= 50; n++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) begin
        pulses++;
        if (first == 0) begin first = n; got = bus.data_result; end
      end
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL busy_ignore_pulses: got %0d want 1", pulses); end
    n_cmp++; if (first != 33) begin n_bad++; $display("FAIL busy_ignore_edge: got %0d want 33", first); end
    n_cmp++; if (got !== er) begin n_bad++; $display("FAIL busy_ignore_result: got %h want %h", got, er); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] er1, er2, er3;
    logic        ee1, ee2, ee3;
    int          lat;
    logic        bok;
    ref_model(1'b0, 32'hFFFF_FF00, 32'd77, er1, ee1);
    ref_model(1'b1, 32'hFFFF_D8F1, 32'd13, er2, ee2);
    ref_model(1'b1, 32'd999, 32'hFFFF_FFF0, er3, ee3);
    start_op(1'b1, 1'b0, 32'hFFFF_FF00, 32'd77);
    repeat (32) @(posedge clock);    // E32
    @(negedge clock);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'hFFFF_D8F1;
    bus.data_operandB = 32'd13;
    @(posedge clock);                // E33: finalize of op1, start of op2
    #1;
    bus.ctrl_DIV = 1'b0;
    n_cmp++; if (bus.data_resultRDY !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy1: got %b want 1", bus.data_resultRDY); end
    n_cmp++; if (bus.data_result !== er1) begin n_bad++; $display("FAIL b2b_result1: got %h want %h", bus.data_result, er1); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", bus.busy); end
    wait_rdy(lat, bok);
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL b2b_latency2: got %0d want 33", lat); end
    n_cmp++; if (bus.data_result !== er2 || bus.data_exception !== ee2) begin n_bad++; $display("FAIL b2b_result2: got %h/%b want %h/%b", bus.data_result, bus.data_exception, er2, ee2); end
    // Start sampled during the DONE cycle.
    start_op(1'b0, 1'b1, 32'd999, 32'hFFFF_FFF0);
    wait_rdy(lat, bok);
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL b2b_latency3: got %0d want 33", lat); end
    n_cmp++; if (bus.data_result !== er3 || bus.data_exception !== ee3) begin n_bad++; $display("FAIL b2b_result3: got %h/%b want %h/%b", bus.data_result, bus.data_exception, er3, ee3); end
  endtask

  task automatic test_both;
    int   lat;
    logic bok;
    start_op(1'b1, 1'b1, 32'd12, 32'd3);
    wait_rdy(lat, bok);
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL both_latency: got %0d want 33", lat); end
    n_cmp++; if (bus.data_result !== 32'd36) begin n_bad++; $display("FAIL both_is_mul: got %h want 00000024", bus.data_result); end
  endtask

  task automatic test_reset_mid;
    int   pulses;
    int   lat;
    logic bok;
    start_op(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (15) @(posedge clock);    // E15
    #2 ctrl_reset = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ctrl: got busy %b rdy %b want 0/0", bus.busy, bus.data_resultRDY); end
    n_cmp++; if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0) begin n_bad++; $display("FAIL rst_mid_data: got %h/%b want 0/0", bus.data_result, bus.data_exception); end
    repeat (2) @(negedge clock);
    ctrl_reset = 1'b1;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY || bus.busy) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL rst_mid_aborted: got %0d active cycles want 0", pulses); end
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    wait_rdy(lat, bok);
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL rst_mid_latency: got %0d want 33", lat); end
    n_cmp++; if (bus.data_result !== 32'd12) begin n_bad++; $display("FAIL rst_mid_result: got %h want 0000000c", bus.data_result); end
  endtask

  initial begin
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    test_reset;
    test_mul_basic;
    test_directed;
    test_random;
    test_busy_ignore;
    test_back_to_back;
    test_both;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
